// File: rtl/sram_1rw1r_wmask_model.sv
// sram_1rw1r_wmask_model: behavioural 1RW+1R SRAM with lane write mask, range checks and 1-2 cycle read latency
module sram_1rw1r_wmask_model #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_WMASKS   = 2,
  parameter int ADDR_WIDTH   = 9,
  parameter int RAM_DEPTH    = 384,
  parameter int READ_LATENCY = 1,
  parameter bit VERBOSE      = 1'b0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic [1:0]            addr_err,
  output logic                  collision
);
  localparam int LW = DATA_WIDTH / NUM_WMASKS;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  typedef struct packed {
    logic                  v0;
    logic                  e0;
    logic [DATA_WIDTH-1:0] d0;
    logic                  v1;
    logic                  e1;
    logic [DATA_WIDTH-1:0] d1;
    logic                  c;
  } rd_t;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  wr0, ok0, ok1, werr;
  rd_t                   a, f, p_d, p_q;
  logic [DATA_WIDTH-1:0] dout0_d, dout0_q, dout1_d, dout1_q;
  logic                  v0_d, v0_q, v1_d, v1_q, coll_d, coll_q;
  logic [1:0]            err_d, err_q;
  // decode requests, fetch pre-write words, and pick the stage that feeds the outputs
  always_comb begin
    wr0 = !csb0 && !web0;
    ok0 = {1'b0, addr0} < DEPTH;
    ok1 = {1'b0, addr1} < DEPTH;
    werr = wr0 && !ok0;
    a.v0 = !csb0 && web0;
    a.e0 = a.v0 && !ok0;
    a.d0 = ok0 ? mem[addr0] : '0;
    a.v1 = !csb1;
    a.e1 = a.v1 && !ok1;
    a.d1 = ok1 ? mem[addr1] : '0;
    a.c = a.v1 && wr0 && ok0 && addr0 == addr1;
    p_d = a;
    f = (READ_LATENCY == 2) ? p_q : a;
    dout0_d = f.v0 ? f.d0 : dout0_q;
    dout1_d = f.v1 ? f.d1 : dout1_q;
    v0_d = f.v0;
    v1_d = f.v1;
    err_d = {f.e1, f.e0 | werr};
    coll_d = f.c;
  end
  // read pipeline and output registers; reset drops any reads still in flight
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      p_q <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      err_q <= '0;
      coll_q <= 1'b0;
    end else begin
      p_q <= p_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      err_q <= err_d;
      coll_q <= coll_d;
    end
  end
  // commit enabled lanes of an in-range port 0 write; contents survive reset
  always_ff @(posedge clk0) begin
    for (int i = 0; i < NUM_WMASKS; i++)
      if (wr0 && ok0 && wmask0[i]) mem[addr0][i*LW +: LW] <= din0[i*LW +: LW];
  end
  assign dout0 = dout0_q;
  assign dout0_valid = v0_q;
  assign dout1 = dout1_q;
  assign dout1_valid = v1_q;
  assign addr_err = err_q;
  assign collision = coll_q;
  if (VERBOSE) begin : g_verbose
    // narrate accepted requests and range errors
    always_ff @(posedge clk0) begin
      if (!rst0 && wr0) $info("sram wr addr=%0d din=%h mask=%b%s", addr0, din0, wmask0, ok0 ? "" : " out of range");
      if (!rst0 && a.v0) $info("sram rd0 addr=%0d%s", addr0, ok0 ? "" : " out of range");
      if (!rst0 && a.v1) $info("sram rd1 addr=%0d%s", addr1, ok1 ? "" : " out of range");
    end
  end
  if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_chk_lane
    $error("DATA_WIDTH must be a multiple of NUM_WMASKS");
  end
  if (RAM_DEPTH > 2**ADDR_WIDTH) begin : g_chk_depth
    $error("RAM_DEPTH exceeds 2**ADDR_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_chk_lat
    $error("READ_LATENCY must be 1 or 2");
  end
endmodule

// File: tb/tb_sram_1rw1r_wmask_model.sv
// tb_sram_1rw1r_wmask_model: directed checks of latency-1 and latency-2 instances driven in lockstep
module tb_sram_1rw1r_wmask_model;
  logic        clk0 = 1'b0;
  logic        rst0, csb0, web0, csb1;
  logic [1:0]  wmask0;
  logic [8:0]  addr0, addr1;
  logic [15:0] din0;
  logic [15:0] o1_d0, o1_d1, o2_d0, o2_d1;
  logic        o1_v0, o1_v1, o1_c, o2_v0, o2_v1, o2_c;
  logic [1:0]  o1_e, o2_e;
  int          tests = 0;
  int          fails = 0;

  always #5 clk0 = ~clk0;

  sram_1rw1r_wmask_model #(.READ_LATENCY(1)) u1 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(o1_d0), .dout0_valid(o1_v0), .csb1(csb1), .addr1(addr1), .dout1(o1_d1), .dout1_valid(o1_v1),
    .addr_err(o1_e), .collision(o1_c));

  sram_1rw1r_wmask_model #(.READ_LATENCY(2)) u2 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(o2_d0), .dout0_valid(o2_v0), .csb1(csb1), .addr1(addr1), .dout1(o2_d1), .dout1_valid(o2_v1),
    .addr_err(o2_e), .collision(o2_c));

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 2'b00; addr0 = '0; din0 = '0; csb1 = 1'b1; addr1 = '0;
  endtask

  task automatic p0w(input logic [8:0] a, input logic [15:0] d, input logic [1:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic p0r(input logic [8:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
  endtask

  task automatic p1r(input logic [8:0] a);
    csb1 = 1'b0; addr1 = a;
  endtask

  task automatic test_reset();
    idle();
    rst0 = 1'b0;
    #1 rst0 = 1'b1;
    #2;
    tests++;
    if ({o1_d0, o1_v0, o1_d1, o1_v1, o1_e, o1_c} !== 37'd0) begin
      fails++; $display("FAIL reset_l1 got %h want 0", {o1_d0, o1_v0, o1_d1, o1_v1, o1_e, o1_c});
    end
    tests++;
    if ({o2_d0, o2_v0, o2_d1, o2_v1, o2_e, o2_c} !== 37'd0) begin
      fails++; $display("FAIL reset_l2 got %h want 0", {o2_d0, o2_v0, o2_d1, o2_v1, o2_e, o2_c});
    end
    @(negedge clk0);
    @(negedge clk0);
    rst0 = 1'b0;
  endtask

  task automatic test_full_rw();
    logic [15:0] exp1, exp2;
    for (int k = 0; k < 384; k++) begin
      @(negedge clk0);
      idle();
      p0w(9'(k), 16'(k) ^ 16'hA5A5, 2'b11);
    end
    for (int c = 0; c < 386; c++) begin
      @(negedge clk0);
      exp1 = 16'(c - 1) ^ 16'hA5A5;
      exp2 = 16'(c - 2) ^ 16'hA5A5;
      tests++;
      if (c >= 1 && c <= 384) begin
        if ({o1_v0, o1_d0, o1_v1, o1_d1} !== {1'b1, exp1, 1'b1, exp1}) begin
          fails++; $display("FAIL full_l1 c=%0d got %b %h %b %h want 1 %h", c, o1_v0, o1_d0, o1_v1, o1_d1, exp1);
        end
      end else if ({o1_v0, o1_v1} !== 2'b00) begin
        fails++; $display("FAIL full_l1_novalid c=%0d got %b%b want 00", c, o1_v0, o1_v1);
      end
      tests++;
      if (c >= 2) begin
        if ({o2_v0, o2_d0, o2_v1, o2_d1} !== {1'b1, exp2, 1'b1, exp2}) begin
          fails++; $display("FAIL full_l2 c=%0d got %b %h %b %h want 1 %h", c, o2_v0, o2_d0, o2_v1, o2_d1, exp2);
        end
      end else if ({o2_v0, o2_v1} !== 2'b00) begin
        fails++; $display("FAIL full_l2_novalid c=%0d got %b%b want 00", c, o2_v0, o2_v1);
      end
      idle();
      if (c < 384) begin
        p0r(9'(c));
        p1r(9'(c));
      end
    end
  endtask

  task automatic test_masked();
    @(negedge clk0); idle(); p0w(9'd10, 16'h1234, 2'b11);
    @(negedge clk0); idle(); p0w(9'd10, 16'hABCD, 2'b01);
    @(negedge clk0); idle(); p0r(9'd10);
    @(negedge clk0); idle();
    tests++;
    if ({o1_v0, o1_d0} !== {1'b1, 16'h12CD}) begin
      fails++; $display("FAIL mask01_l1 got %b %h want 1 12cd", o1_v0, o1_d0);
    end
    @(negedge clk0); idle(); p0w(9'd10, 16'hFFFF, 2'b00);
    tests++;
    if ({o2_v0, o2_d0} !== {1'b1, 16'h12CD}) begin
      fails++; $display("FAIL mask01_l2 got %b %h want 1 12cd", o2_v0, o2_d0);
    end
    @(negedge clk0); idle(); p0r(9'd10);
    tests++;
    if ({o1_v0, o2_v0} !== 2'b00) begin
      fails++; $display("FAIL write_no_valid got %b%b want 00", o1_v0, o2_v0);
    end
    @(negedge clk0); idle();
    tests++;
    if ({o1_v0, o1_d0} !== {1'b1, 16'h12CD}) begin
      fails++; $display("FAIL mask00_l1 got %b %h want 1 12cd", o1_v0, o1_d0);
    end
    @(negedge clk0);
    tests++;
    if ({o2_v0, o2_d0} !== {1'b1, 16'h12CD}) begin
      fails++; $display("FAIL mask00_l2 got %b %h want 1 12cd", o2_v0, o2_d0);
    end
  endtask

  task automatic test_collision();
    @(negedge clk0); idle(); p0w(9'd5, 16'h0001, 2'b11);
    @(negedge clk0); idle(); p0w(9'd5, 16'h0002, 2'b11); p1r(9'd5);
    @(negedge clk0); idle(); p1r(9'd5);
    tests++;
    if ({o1_v1, o1_d1, o1_c, o1_v0} !== {1'b1, 16'h0001, 1'b1, 1'b0}) begin
      fails++; $display("FAIL coll_l1 got %b %h %b %b want 1 0001 1 0", o1_v1, o1_d1, o1_c, o1_v0);
    end
    @(negedge clk0); idle();
    tests++;
    if ({o1_v1, o1_d1, o1_c} !== {1'b1, 16'h0002, 1'b0}) begin
      fails++; $display("FAIL coll_next_l1 got %b %h %b want 1 0002 0", o1_v1, o1_d1, o1_c);
    end
    tests++;
    if ({o2_v1, o2_d1, o2_c, o2_v0} !== {1'b1, 16'h0001, 1'b1, 1'b0}) begin
      fails++; $display("FAIL coll_l2 got %b %h %b %b want 1 0001 1 0", o2_v1, o2_d1, o2_c, o2_v0);
    end
    @(negedge clk0);
    tests++;
    if ({o2_v1, o2_d1, o2_c} !== {1'b1, 16'h0002, 1'b0}) begin
      fails++; $display("FAIL coll_next_l2 got %b %h %b want 1 0002 0", o2_v1, o2_d1, o2_c);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk0); idle(); p0w(9'd400, 16'hFFFF, 2'b11);
    @(negedge clk0); idle(); p1r(9'd400); p0r(9'd383);
    tests++;
    if ({o1_e, o1_c, o2_e, o2_c} !== 6'b01_0_01_0) begin
      fails++; $display("FAIL oor_wr_err got %b%b %b%b want 010 010", o1_e, o1_c, o2_e, o2_c);
    end
    @(negedge clk0); idle();
    tests++;
    if ({o1_v0, o1_d0, o1_v1, o1_d1, o1_e} !== {1'b1, 16'hA4DA, 1'b1, 16'h0000, 2'b10}) begin
      fails++; $display("FAIL oor_rd_l1 got %b %h %b %h %b want 1 a4da 1 0000 10", o1_v0, o1_d0, o1_v1, o1_d1, o1_e);
    end
    tests++;
    if ({o2_v0, o2_v1, o2_e} !== 4'b0000) begin
      fails++; $display("FAIL oor_early_l2 got %b %b %b want 0 0 00", o2_v0, o2_v1, o2_e);
    end
    @(negedge clk0);
    tests++;
    if ({o2_v0, o2_d0, o2_v1, o2_d1, o2_e} !== {1'b1, 16'hA4DA, 1'b1, 16'h0000, 2'b10}) begin
      fails++; $display("FAIL oor_rd_l2 got %b %h %b %h %b want 1 a4da 1 0000 10", o2_v0, o2_d0, o2_v1, o2_d1, o2_e);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk0); idle(); p0r(9'd10);
    @(negedge clk0); idle();
    tests++;
    if ({o1_v0, o1_d0} !== {1'b1, 16'h12CD}) begin
      fails++; $display("FAIL pre_rst_l1 got %b %h want 1 12cd", o1_v0, o1_d0);
    end
    rst0 = 1'b1;
    #1;
    tests++;
    if ({o1_d0, o1_v0, o2_d0, o2_v0, o1_d1, o2_d1, o1_e, o2_e} !== 70'd0) begin
      fails++; $display("FAIL async_rst got %h %b %h %b want 0", o1_d0, o1_v0, o2_d0, o2_v0);
    end
    #1 rst0 = 1'b0;
    @(negedge clk0);
    tests++;
    if ({o2_v0, o2_d0, o1_v0} !== 18'd0) begin
      fails++; $display("FAIL rst_drop_l2 got %b %h %b want 0 0000 0", o2_v0, o2_d0, o1_v0);
    end
    @(negedge clk0); idle(); p0r(9'd10);
    tests++;
    if (o2_v0 !== 1'b0) begin
      fails++; $display("FAIL rst_drop2_l2 got %b want 0", o2_v0);
    end
    @(negedge clk0); idle();
    tests++;
    if ({o1_v0, o1_d0} !== {1'b1, 16'h12CD}) begin
      fails++; $display("FAIL post_rst_l1 got %b %h want 1 12cd", o1_v0, o1_d0);
    end
    @(negedge clk0);
    tests++;
    if ({o2_v0, o2_d0} !== {1'b1, 16'h12CD}) begin
      fails++; $display("FAIL post_rst_l2 got %b %h want 1 12cd", o2_v0, o2_d0);
    end
  endtask

  initial begin
    test_reset();
    test_full_rw();
    test_masked();
    test_collision();
    test_out_of_range();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
